vga_pic_jump: RTL

- Pixel-source stage driving vga_ctrl's pix_data input; replaces the static picture generator in the ROM-picture display path.
- Draws a PIC_W x PIC_H RGB565 image, fetched from an external synchronous ROM, at a position that steps once per frame and bounces off the active-area edges.
- Fills every pixel outside the picture with BG_COLOR.
- Consumes the pix_x/pix_y produced by vga_ctrl. vga_ctrl compensates for the fixed 3-cycle latency by requesting pixels 3 cycles early.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_pic_mover.sv | 80 ++++++++
 rtl/vga_pic_jump.sv | 80 ++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants: active-area geometry, RGB565 colours and the
// direction encoding used by the bouncing-picture mover.
package vga_pkg;

  localparam int H_VALID = 640;
  localparam int V_VALID = 480;

  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] MAGENTA = 16'hF81F;

  // DIR_POS = RIGHT on x / DOWN on y; DIR_NEG = LEFT on x / UP on y.
  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

endpackage

// File: rtl/vga_pic_mover.sv
// Frame-tick detection and the per-axis bounce FSM for the picture origin.
//
// state   | meaning
// DIR_POS | axis moving towards larger coordinate (RIGHT / DOWN)
// DIR_NEG | axis moving towards smaller coordinate (LEFT / UP)
module vga_pic_mover
  import vga_pkg::*;
#(
  parameter int H_VAL = H_VALID,
  parameter int V_VAL = V_VALID,
  parameter int PIC_W = 100,
  parameter int PIC_H = 100,
  parameter int STEP  = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       move_en,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [9:0] x0,
  output logic [9:0] y0,
  output dir_t       x_dir,
  output dir_t       y_dir
);

  localparam logic [10:0] X_MAX  = 11'(H_VAL - PIC_W);
  localparam logic [10:0] Y_MAX  = 11'(V_VAL - PIC_H);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [9:0]  STEP10 = 10'(STEP);

  logic frame_tick;

  // Tick one cycle after the last active pixel; step/bounce both axes on it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      frame_tick <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      x_dir      <= DIR_POS;
      y_dir      <= DIR_POS;
    end else begin
      frame_tick <= (pix_x == 10'(H_VAL - 1)) && (pix_y == 10'(V_VAL - 1));
      if (frame_tick && move_en) begin
        unique case (x_dir)
          DIR_POS:
            if ({1'b0, x0} + STEP11 >= X_MAX) begin
              x0    <= X_MAX[9:0];
              x_dir <= DIR_NEG;
            end else begin
              x0 <= x0 + STEP10;
            end
          DIR_NEG:
            if ({1'b0, x0} <= STEP11) begin
              x0    <= '0;
              x_dir <= DIR_POS;
            end else begin
              x0 <= x0 - STEP10;
            end
        endcase
        unique case (y_dir)
          DIR_POS:
            if ({1'b0, y0} + STEP11 >= Y_MAX) begin
              y0    <= Y_MAX[9:0];
              y_dir <= DIR_NEG;
            end else begin
              y0 <= y0 + STEP10;
            end
          DIR_NEG:
            if ({1'b0, y0} <= STEP11) begin
              y0    <= '0;
              y_dir <= DIR_POS;
            end else begin
              y0 <= y0 - STEP10;
            end
        endcase
      end
    end
  end

endmodule

// File: rtl/vga_pic_jump.sv
// Pixel source for vga_ctrl: a ROM picture bouncing around the active area
// over a flat background, with a fixed 3-cycle pix_x/pix_y -> pix_data latency.
module vga_pic_jump
  import vga_pkg::*;
#(
  parameter int          H_VAL    = H_VALID,
  parameter int          V_VAL    = V_VALID,
  parameter int          PIC_W    = 100,
  parameter int          PIC_H    = 100,
  parameter int          STEP     = 2,
  parameter int          ADDR_W   = 14,
  parameter logic [15:0] BG_COLOR = WHITE
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              move_en,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       pix_data
);

  logic [9:0]        x0, y0;
  dir_t              x_dir, y_dir;
  logic              in_pic;
  logic [9:0]        dx, dy;
  logic [ADDR_W-1:0] addr_nxt;
  // v* mark real pixels in flight so output stays black until the pipe refills.
  logic              v1, v2, d1, d2;

  vga_pic_mover #(
    .H_VAL (H_VAL),
    .V_VAL (V_VAL),
    .PIC_W (PIC_W),
    .PIC_H (PIC_H),
    .STEP  (STEP)
  ) u_mover (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .move_en (move_en),
    .pix_x   (pix_x),
    .pix_y   (pix_y),
    .x0      (x0),
    .y0      (y0),
    .x_dir   (x_dir),
    .y_dir   (y_dir)
  );

  // Window test at 11 bits so the 10'h3FF "outside" marker never matches.
  always_comb begin
    in_pic = ({1'b0, pix_x} >= {1'b0, x0}) &&
             ({1'b0, pix_x} <  {1'b0, x0} + 11'(PIC_W)) &&
             ({1'b0, pix_y} >= {1'b0, y0}) &&
             ({1'b0, pix_y} <  {1'b0, y0} + 11'(PIC_H));
    dx       = pix_x - x0;
    dy       = pix_y - y0;
    addr_nxt = ADDR_W'(dy) * ADDR_W'(PIC_W) + ADDR_W'(dx);
  end

  // Address stage, ROM wait stage, then colour select.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rom_addr <= '0;
      v1       <= 1'b0;
      d1       <= 1'b0;
      v2       <= 1'b0;
      d2       <= 1'b0;
      pix_data <= 16'h0000;
    end else begin
      rom_addr <= in_pic ? addr_nxt : '0;
      v1       <= 1'b1;
      d1       <= in_pic;
      v2       <= v1;
      d2       <= d1;
      pix_data <= v2 ? (d2 ? rom_data : BG_COLOR) : 16'h0000;
    end
  end

endmodule
